// File: rtl/taylor_trig_unit_pkg.sv
// Shared definitions for the Taylor-series cos/sin unit: FSM encoding,
// the fixed-point 1.0 constant and the series coefficient generator.
package taylor_trig_unit_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQR,
      S_MULX,
      S_MULC,
      S_ACC,
      S_DONE
   } state_t;

   function automatic int unsigned one_q(input int frac);
      return 32'd1 << frac;
   endfunction

   // 1/d in Q.frac, rounded to nearest with ties up, never below 1.
   // cos: d=(2k-1)(2k); sin: d=(2k)(2k+1)
   function automatic int unsigned coef_val(input int frac, input bit sin_mode, input int k);
      int unsigned d;
      int unsigned v;
      d = sin_mode ? (2*k) * (2*k + 1) : (2*k - 1) * (2*k);
      v = ((32'd2 << frac) + d) / (2 * d);
      return (v == 0) ? 1 : v;
   endfunction

endpackage

// File: rtl/taylor_trig_unit_if.sv
// Host-side start/done handshake and operand/result bus of the trig unit.
interface taylor_trig_unit_if #(
   parameter int W      = 16,
   parameter int NTERMS = 6
);
   localparam int KW = $clog2(NTERMS + 1);

   logic          start;
   logic          mode;
   logic [W-1:0]  x_in;
   logic [W-1:0]  eps;
   logic          busy;
   logic          done;
   logic [W-1:0]  z;
   logic [KW-1:0] n_terms;

   modport master (output start, mode, x_in, eps, input busy, done, z, n_terms);
   modport slave  (input start, mode, x_in, eps, output busy, done, z, n_terms);
endinterface

// File: rtl/taylor_trig_unit_coef_rom.sv
// Combinational coefficient lookup c(mode,k) for k = 1..NTERMS, unsigned Q.FRAC.
module taylor_coef_rom
   import taylor_trig_unit_pkg::*;
#(
   parameter int FRAC   = 8,
   parameter int NTERMS = 6,
   localparam int KW    = $clog2(NTERMS + 1)
) (
   input  logic          mode,
   input  logic [KW-1:0] k,
   output logic [FRAC-1:0] c
);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      c = '0;
      for (int i = 1; i <= NTERMS; i++) begin
         if (int'(k) == i)
            c = mode ? FRAC'(coef_val(FRAC, 1'b1, i)) : FRAC'(coef_val(FRAC, 1'b0, i));
      end
   end

endmodule

// File: rtl/taylor_trig_unit.sv
// Sequential fixed-point cos/sin Taylor evaluator: one shared WxW multiplier,
// one adder/subtractor, epsilon early exit and a start/done handshake.
module taylor_trig_unit
   import taylor_trig_unit_pkg::*;
#(
   parameter int W      = 16,
   parameter int FRAC   = 8,
   parameter int NTERMS = 6
) (
   input logic              clk,
   input logic              rst,
   taylor_trig_unit_if.slave bus
);

   localparam int KW = $clog2(NTERMS + 1);
   localparam logic [W-1:0] ONE = W'(one_q(FRAC));

   state_t         state, state_nx;
   logic [W-1:0]   x_q, eps_q, x2_q, t_q, r_q, z_q;
   logic [KW-1:0]  k_q, n_q;
   logic           mode_q, done_q;

   logic [FRAC-1:0] coef;
   logic [W-1:0]    op_a, op_b, fx_prod, sum;
   logic [2*W-1:0]  prod;
   logic            accept, last;

   taylor_coef_rom #(.FRAC(FRAC), .NTERMS(NTERMS)) u_rom (
      .mode (mode_q),
      .k    (k_q),
      .c    (coef)
   );

   // Operand mux for the single shared multiplier.
   always_comb begin
      op_a = t_q;
      op_b = x2_q;
      case (state)
         S_SQR:   begin op_a = x_q; op_b = x_q; end
         S_MULC:  op_b = {{(W-FRAC){1'b0}}, coef};
         default: ;
      endcase
   end

   assign prod    = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
   assign fx_prod = (|prod[2*W-1:W+FRAC]) ? '1 : prod[W+FRAC-1:FRAC];

   // Odd terms of both series carry a negative sign.
   assign sum    = k_q[0] ? (r_q - t_q) : (r_q + t_q);
   assign last   = (k_q == KW'(NTERMS)) || (t_q < eps_q);
   // A start seen during the done pulse is dropped; the host retries afterwards.
   assign accept = (state == S_IDLE) && bus.start && !done_q;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_SQR;
         S_SQR:   state_nx = S_MULX;
         S_MULX:  state_nx = S_MULC;
         S_MULC:  state_nx = S_ACC;
         S_ACC:   state_nx = last ? S_DONE : S_MULX;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         x_q    <= '0;
         eps_q  <= '0;
         x2_q   <= '0;
         t_q    <= '0;
         r_q    <= '0;
         z_q    <= '0;
         k_q    <= '0;
         n_q    <= '0;
         mode_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= (state == S_DONE);
         case (state)
            S_IDLE: if (accept) begin
               x_q    <= bus.x_in;
               eps_q  <= bus.eps;
               mode_q <= bus.mode;
               k_q    <= KW'(1);
               t_q    <= bus.mode ? bus.x_in : ONE;
               r_q    <= bus.mode ? bus.x_in : ONE;
            end
            S_SQR:          x2_q <= fx_prod;
            S_MULX, S_MULC: t_q  <= fx_prod;
            S_ACC: begin
               r_q <= sum;
               if (last) begin
                  z_q <= sum;
                  n_q <= k_q;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state != S_IDLE) || done_q;
   assign bus.done    = done_q;
   assign bus.z       = z_q;
   assign bus.n_terms = n_q;

endmodule

// File: tb/tb_taylor_trig_unit.sv
// Directed table-driven bench for taylor_trig_unit (W=16, FRAC=8, NTERMS=6).
module tb_taylor_trig_unit;

   localparam int W      = 16;
   localparam int FRAC   = 8;
   localparam int NTERMS = 6;
   localparam int MAXLAT = 100;

   typedef struct {
      string       name;
      logic        mode;
      logic [15:0] x;
      logic [15:0] eps;
      logic [15:0] z;
      int          n;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   taylor_trig_unit_if #(.W(W), .NTERMS(NTERMS)) bus ();

   taylor_trig_unit #(.W(W), .FRAC(FRAC), .NTERMS(NTERMS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic launch(input logic m, input logic [15:0] x, input logic [15:0] e);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.x_in  = x;
      bus.eps   = e;
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      while (!bus.done && (cyc - acc_cyc) < MAXLAT) begin
         @(posedge clk);
         #1;
      end
      lat = cyc - acc_cyc;
   endtask

   // Run one operation and check result, latency and the done/busy pulse shape.
   task automatic run_vec(input vec_t v);
      int lat;
      launch(v.mode, v.x, v.eps);
      wait_done(lat);
      check({v.name, " latency"}, lat, v.lat);
      check({v.name, " z"}, bus.z, v.z);
      check({v.name, " n_terms"}, bus.n_terms, v.n);
      check({v.name, " busy at done"}, bus.busy, 1);
      @(posedge clk);
      #1;
      check({v.name, " done pulse width"}, bus.done, 0);
      check({v.name, " busy after done"}, bus.busy, 0);
      check({v.name, " z held"}, bus.z, v.z);
   endtask

   vec_t vecs[12];

   initial begin
      int lat;
      int extra;

      vecs[0]  = '{"cos1",       1'b0, 16'd256,    16'd1,      16'd138,    3, 11};
      vecs[1]  = '{"sin1",       1'b1, 16'd256,    16'd1,      16'd215,    3, 11};
      vecs[2]  = '{"cos0",       1'b0, 16'd0,      16'd1,      16'd256,    1, 5};
      vecs[3]  = '{"cos1_cap",   1'b0, 16'd256,    16'd0,      16'd138,    6, 20};
      vecs[4]  = '{"cos_half",   1'b0, 16'd128,    16'd1,      16'd224,    2, 8};
      vecs[5]  = '{"sin_half",   1'b1, 16'd128,    16'd1,      16'd123,    2, 8};
      vecs[6]  = '{"cos_pi2",    1'b0, 16'd402,    16'd1,      16'hFFFF,   4, 14};
      vecs[7]  = '{"eps_equal",  1'b0, 16'd256,    16'd128,    16'd138,    2, 8};
      vecs[8]  = '{"eps_above",  1'b0, 16'd256,    16'd129,    16'd128,    1, 5};
      vecs[9]  = '{"sin_sat",    1'b1, 16'hFFFF,   16'h3000,   16'hD500,   1, 5};
      vecs[10] = '{"cos_sat",    1'b0, 16'hFFFF,   16'h8000,   16'h8101,   1, 5};
      vecs[11] = '{"sin0",       1'b1, 16'd0,      16'd1,      16'd0,      1, 5};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.x_in  = '0;
      bus.eps   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset z", bus.z, 0);
      check("reset n_terms", bus.n_terms, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // A start pulse during an operation must be ignored entirely.
      launch(1'b0, 16'd256, 16'd1);
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 1'b1;
      bus.x_in  = 16'd0;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat);
      check("ignore latency", lat, 11);
      check("ignore z", bus.z, 138);
      check("ignore n_terms", bus.n_terms, 3);
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) extra++;
      end
      check("ignore no second done", extra, 0);
      check("ignore z held", bus.z, 138);

      // Reset while in MULC: accept edge -> SQR, +1 -> MULX, +2 -> MULC.
      launch(1'b0, 16'd256, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst busy", bus.busy, 0);
      check("midrst done", bus.done, 0);
      check("midrst z", bus.z, 0);
      check("midrst n_terms", bus.n_terms, 0);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) extra++;
      end
      check("midrst no done", extra, 0);
      run_vec('{"after_rst_sin1", 1'b1, 16'd256, 16'd1, 16'd215, 3, 11});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
